firing_controller: RTL
======================

# firing_controller

Multi-player ammunition and firing controller for the Duck Hunt game core. One independent channel per player tracks remaining shots, enforces a post-shot cooldown, runs a timed reload and flags dry fires. It sits between the debounced trigger/reload inputs and the hit-detection and HUD logic. Its registered per-shot pulse is the sole qualifier for hit checks.

## Interface
- SHOTS_MAX, 3: shots per full magazine; must be ≥1.
- PLAYERS, 2: number of independent channels; must be ≥1.
- COOLDOWN_CYCLES, 4: cycles between an accepted shot and the next accepted shot; 0 allowed.
- RELOAD_CYCLES, 16: cycles spent in reload; must be ≥1.
- SW (localparam): $clog2(SHOTS_MAX+1), width of each shot count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- round_start  in  1  synchronous restart of all channels.
- fire  in  PLAYERS  per-player trigger, level-sampled.
- reload_req  in  PLAYERS  per-player reload request, level-sampled.
- shots_left  out  PLAYERS*SW  packed counts; player p occupies bits [p*SW +: SW].
- shot_fired  out  PLAYERS  one-cycle pulse per accepted shot.
- dry_fire  out  PLAYERS  one-cycle pulse for a trigger pulled on an empty magazine in READY.
- reloading  out  PLAYERS  high while the channel is in RELOAD.
- empty  out  PLAYERS  high when the channel's shots_left is 0 (combinational from the count register).

## Operation
- Per-channel FSM with states READY, COOLDOWN and RELOAD. Each channel has a timer sized to max(COOLDOWN_CYCLES, RELOAD_CYCLES).
- Reset, asynchronous: all channels go to READY, shots_left=SHOTS_MAX, timers=0, and every pulse/status output is 0 except empty=0.
- round_start, synchronous: same effect as reset. It overrides every other input on that edge.
- READY with fire=1 and shots>0:
  - count decrements by 1 and shot_fired pulses.
  - goes to COOLDOWN if COOLDOWN_CYCLES>0, otherwise stays in READY.
- READY with fire=1 and shots=0: dry_fire pulses; state and count are unchanged.
- READY with fire=0, reload_req=1 and shots<SHOTS_MAX: goes to RELOAD and the timer loads.
- A reload_req at a full magazine is ignored.
- fire and reload_req on the same edge: fire wins; the reload is dropped, not queued.
- COOLDOWN: after exactly COOLDOWN_CYCLES cycles, returns to READY. fire and reload_req are ignored with no pulses.
- RELOAD: after exactly RELOAD_CYCLES cycles, count becomes SHOTS_MAX and state returns to READY. fire and reload_req are ignored with no pulses.
- The count never wraps below 0 or above SHOTS_MAX.
- Channels are fully independent; simultaneous events on different players do not interact.

## Timing
- A fire sampled at edge N in READY gives shots_left and shot_fired updated after edge N.
  - shot_fired is high for one cycle.
  - The next shot is accepted no earlier than edge N+COOLDOWN_CYCLES+1.
- With COOLDOWN_CYCLES=0 and fire held, one shot is accepted per cycle until empty. dry_fire then pulses every cycle while fire stays held.
- A reload_req accepted at edge M:
  - reloading is high from after M until after M+RELOAD_CYCLES.
  - shots_left=SHOTS_MAX after edge M+RELOAD_CYCLES.
  - A fire at edge M+RELOAD_CYCLES+1 is accepted.
- All outputs are registered except empty.
- Reset or round_start mid-COOLDOWN or mid-RELOAD aborts the operation immediately and restores full ammunition.

## Configuration
- AUTO_RELOAD_EN:
  - Defined: when an accepted shot leaves the count at 0, the channel enters RELOAD directly, skipping COOLDOWN. reloading rises on the same edge the count reaches 0, and reload_req remains functional.
  - Undefined: an empty channel stays in READY, dry-firing, until reload_req is asserted.

## Structure
- Shared package firing_pkg:
  - fire_state_t enum {READY, COOLDOWN, RELOAD}.
  - Default constants for SHOTS_MAX, COOLDOWN_CYCLES and RELOAD_CYCLES.
- Sub-module firing_channel implements one player's FSM, count and timer. The top level generates PLAYERS instances and packs their outputs.

## Test plan
- Defaults, reset released, then fire[0] pulsed at 3 widely spaced edges → shots_left[0] goes 3,2,1,0; three shot_fired[0] pulses; empty[0]=1. A fourth fire gives dry_fire[0] and the count stays 0.
- fire[0] held continuously, COOLDOWN_CYCLES=4 → shot_fired[0] at edges N, N+5 and N+10, then empty.
- After 2 shots, reload_req[0] at edge M with RELOAD_CYCLES=16 → reloading[0] high for 16 cycles; shots_left[0]=3 after M+16. Fire during the reload produces no pulse.
- fire[1] and reload_req[1] on the same edge with 3 shots → shot fired, count 2, no reload. Meanwhile player 0 fires independently on the same edge → both counts decrement.
- round_start at cycle 8 of a reload → shots_left=3 and READY on the next edge. A reset pulse mid-COOLDOWN gives an asynchronous return to defaults.
- With AUTO_RELOAD_EN defined, the third shot → reloading[0] rises with the count at 0, and the count is 3 after 16 cycles. With the macro undefined, the channel stays empty.

Source files
------------

// File: rtl/firing_pkg.sv
// Shared definitions for the Duck Hunt firing controller.
//   fire_state_t : per-channel FSM states (READY, COOLDOWN, RELOAD)
//   *_DEF        : default magazine size, cooldown and reload lengths
//   max_u        : helper used to size the shared cooldown/reload timer
package firing_pkg;

  typedef enum logic [1:0] {
    READY,
    COOLDOWN,
    RELOAD
  } fire_state_t;

  localparam int unsigned SHOTS_MAX_DEF       = 3;
  localparam int unsigned COOLDOWN_CYCLES_DEF = 4;
  localparam int unsigned RELOAD_CYCLES_DEF   = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/firing_channel.sv
// One player's ammunition channel: shot count, post-shot cooldown, timed
// reload and dry-fire detection.
// Optional feature macro: AUTO_RELOAD_EN (an emptying shot goes straight to
// RELOAD instead of COOLDOWN).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   round_start       synchronous restart (same effect as reset)
//   fire, reload_req  level-sampled trigger / reload request
//   shots_left        remaining shots (registered)
//   shot_fired        one-cycle pulse per accepted shot (registered)
//   dry_fire          one-cycle pulse for a trigger on an empty magazine
//   reloading         high while in RELOAD
//   empty             shots_left == 0 (combinational)
module firing_channel
  import firing_pkg::*;
#(
  parameter int unsigned SHOTS_MAX       = SHOTS_MAX_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter int unsigned RELOAD_CYCLES   = RELOAD_CYCLES_DEF,
  localparam int unsigned SW             = $clog2(SHOTS_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          round_start,
  input  logic          fire,
  input  logic          reload_req,
  output logic [SW-1:0] shots_left,
  output logic          shot_fired,
  output logic          dry_fire,
  output logic          reloading,
  output logic          empty
);

  localparam int unsigned TW = $clog2(max_u(COOLDOWN_CYCLES, RELOAD_CYCLES) + 1);
  localparam logic [SW-1:0] FULL     = SW'(SHOTS_MAX);
  localparam logic [TW-1:0] T_COOL   = TW'(COOLDOWN_CYCLES);
  localparam logic [TW-1:0] T_RELOAD = TW'(RELOAD_CYCLES);

  fire_state_t   state_q, state_d;
  logic [SW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          shot_q, shot_d;
  logic          dry_q, dry_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= READY;
      count_q <= FULL;
      timer_q <= '0;
      shot_q  <= 1'b0;
      dry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      shot_q  <= shot_d;
      dry_q   <= dry_d;
    end
  end

  // The timer holds the number of cycles still to spend in the current
  // state; the state is left on the edge where it reads 1, so a load of N
  // gives exactly N cycles in COOLDOWN/RELOAD.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    shot_d  = 1'b0;
    dry_d   = 1'b0;
    if (round_start) begin
      state_d = READY;
      count_d = FULL;
      timer_d = '0;
    end else begin
      unique case (state_q)
        READY: begin
          if (fire) begin
            if (count_q != '0) begin
              count_d = count_q - SW'(1);
              shot_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
              if (count_q == SW'(1)) begin
                state_d = RELOAD;
                timer_d = T_RELOAD;
              end else
`endif
              if (COOLDOWN_CYCLES > 0) begin
                state_d = COOLDOWN;
                timer_d = T_COOL;
              end
            end else begin
              dry_d = 1'b1;
            end
          end else if (reload_req && count_q != FULL) begin
            state_d = RELOAD;
            timer_d = T_RELOAD;
          end
        end
        COOLDOWN: begin
          if (timer_q <= TW'(1)) begin
            state_d = READY;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        RELOAD: begin
          if (timer_q <= TW'(1)) begin
            state_d = READY;
            count_d = FULL;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = READY;
          timer_d = '0;
        end
      endcase
    end
  end

  assign shots_left = count_q;
  assign shot_fired = shot_q;
  assign dry_fire   = dry_q;
  assign reloading  = (state_q == RELOAD);
  assign empty      = (count_q == '0);

endmodule

// File: rtl/firing_controller.sv
// Multi-player ammunition and firing controller: PLAYERS independent
// firing_channel instances with their outputs packed per player.
// Optional feature macro: AUTO_RELOAD_EN (see firing_channel).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   round_start       synchronous restart of all channels
//   fire, reload_req  per-player trigger / reload request
//   shots_left        packed counts, player p at [p*SW +: SW]
//   shot_fired        per-player accepted-shot pulse
//   dry_fire          per-player empty-trigger pulse
//   reloading         per-player RELOAD status
//   empty             per-player shots_left == 0
module firing_controller
  import firing_pkg::*;
#(
  parameter int unsigned SHOTS_MAX       = SHOTS_MAX_DEF,
  parameter int unsigned PLAYERS         = 2,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter int unsigned RELOAD_CYCLES   = RELOAD_CYCLES_DEF,
  localparam int unsigned SW             = $clog2(SHOTS_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  round_start,
  input  logic [PLAYERS-1:0]    fire,
  input  logic [PLAYERS-1:0]    reload_req,
  output logic [PLAYERS*SW-1:0] shots_left,
  output logic [PLAYERS-1:0]    shot_fired,
  output logic [PLAYERS-1:0]    dry_fire,
  output logic [PLAYERS-1:0]    reloading,
  output logic [PLAYERS-1:0]    empty
);

  for (genvar p = 0; p < PLAYERS; p++) begin : g_ch
    firing_channel #(
      .SHOTS_MAX       (SHOTS_MAX),
      .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
      .RELOAD_CYCLES   (RELOAD_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .round_start (round_start),
      .fire        (fire[p]),
      .reload_req  (reload_req[p]),
      .shots_left  (shots_left[p*SW +: SW]),
      .shot_fired  (shot_fired[p]),
      .dry_fire    (dry_fire[p]),
      .reloading   (reloading[p]),
      .empty       (empty[p])
    );
  end

endmodule
